pu_mac_pipe: RTL

//  Parametrised pipelined neuron processing unit. Computes LANES signed products a_i*w_i per beat,

---
 rtl/pu_mac_pipe.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/pu_mac_pipe.sv
// Pipelined neuron processing unit: LANES signed products per beat, adder-tree
// reduction, saturating accumulation per vector, then activation, shift and clamp.
module pu_mac_pipe #(
   parameter int LANES = 4,
   parameter int DW    = 5,
   parameter int ACCW  = 16,
   parameter int SHIFT = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_last,
   input  logic                   act_mode,
   input  logic [LANES*DW-1:0]    a_flat,
   input  logic [LANES*DW-1:0]    w_flat,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic signed [DW-1:0]   out_data,
   output logic                   out_sat
);

   localparam int PW = 2 * DW;
   localparam int TW = PW + $clog2(LANES);
   localparam int SW = ACCW + 1;

   generate
      if (LANES < 1) begin : g_bad_lanes
         $error("pu_mac_pipe: LANES must be >= 1");
      end
      if (DW < 2) begin : g_bad_dw
         $error("pu_mac_pipe: DW must be >= 2");
      end
      if (ACCW < TW) begin : g_bad_accw
         $error("pu_mac_pipe: ACCW must be >= 2*DW+clog2(LANES)");
      end
   endgenerate

   function automatic logic signed [PW-1:0] mul(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
      logic signed [PW-1:0] ax;
      logic signed [PW-1:0] bx;
      ax = PW'(a);
      bx = PW'(b);
      return ax * bx;
   endfunction

   // One extra bit holds any ACCW+ACCW sum; overflow shows as differing top bits.
   function automatic logic acc_ovf(input logic signed [SW-1:0] s);
      return s[SW-1] != s[SW-2];
   endfunction

   function automatic logic signed [ACCW-1:0] sat_acc(input logic signed [SW-1:0] s);
      if (acc_ovf(s))
         return s[SW-1] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
      return s[ACCW-1:0];
   endfunction

   function automatic logic out_ovf(input logic signed [ACCW-1:0] x);
      logic [ACCW-DW:0] top;
      top = x[ACCW-1:DW-1];
      return !((&top) || (~|top));
   endfunction

   function automatic logic signed [DW-1:0] sat_out(input logic signed [ACCW-1:0] x);
      if (out_ovf(x))
         return x[ACCW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      return x[DW-1:0];
   endfunction

   logic                   stall;
   logic                   en;
   logic                   accept;

   logic signed [PW-1:0]   prod_p1_q [LANES];
   logic signed [PW-1:0]   prod_p1_d [LANES];
   logic                   vld_p1_q, vld_p1_d;
   logic                   last_p1_q, last_p1_d;
   logic                   mode_p1_q, mode_p1_d;

   logic signed [ACCW-1:0] acc_q, acc_d;
   logic                   acc_sat_q, acc_sat_d;
   logic                   first_q, first_d;
   logic                   fire_p2_q, fire_p2_d;
   logic                   mode_p2_q, mode_p2_d;

   logic                   out_valid_q, out_valid_d;
   logic signed [DW-1:0]   out_data_q, out_data_d;
   logic                   out_sat_q, out_sat_d;

   logic signed [DW-1:0]   a_l;
   logic signed [DW-1:0]   w_l;
   logic signed [TW-1:0]   tree;
   logic signed [ACCW-1:0] base;
   logic signed [SW-1:0]   sum;
   logic signed [ACCW-1:0] act_v;
   logic signed [ACCW-1:0] shv;

   always_comb begin
      stall  = out_valid_q & ~out_ready;
      en     = ~stall;
      accept = in_valid & en;

      // S1: lane products, captured only on an accepted beat
      a_l = '0;
      w_l = '0;
      for (int i = 0; i < LANES; i++) begin
         a_l          = a_flat[i*DW +: DW];
         w_l          = w_flat[i*DW +: DW];
         prod_p1_d[i] = accept ? mul(a_l, w_l) : prod_p1_q[i];
      end
      vld_p1_d  = en ? in_valid : vld_p1_q;
      last_p1_d = en ? (in_valid & in_last) : last_p1_q;
      mode_p1_d = accept ? act_mode : mode_p1_q;

      // S2: adder tree and saturating accumulate
      tree = '0;
      for (int i = 0; i < LANES; i++)
         tree = tree + TW'(prod_p1_q[i]);
      base = first_q ? '0 : acc_q;
      sum  = SW'(base) + SW'(tree);

      acc_d     = acc_q;
      acc_sat_d = acc_sat_q;
      first_d   = first_q;
      fire_p2_d = fire_p2_q;
      mode_p2_d = mode_p2_q;
      if (en) begin
         fire_p2_d = vld_p1_q & last_p1_q;
         mode_p2_d = mode_p1_q;
         if (vld_p1_q) begin
            acc_d     = sat_acc(sum);
            acc_sat_d = (first_q ? 1'b0 : acc_sat_q) | acc_ovf(sum);
            first_d   = last_p1_q;
         end
      end

      // S3: activation, arithmetic shift, output clamp
      act_v = (mode_p2_q && acc_q[ACCW-1]) ? '0 : acc_q;
      shv   = act_v >>> SHIFT;

      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sat_d   = out_sat_q;
      if (en) begin
         if (fire_p2_q) begin
            out_valid_d = 1'b1;
            out_data_d  = sat_out(shv);
            out_sat_d   = acc_sat_q | out_ovf(shv);
         end else begin
            out_valid_d = out_valid_q & ~out_ready;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LANES; i++)
            prod_p1_q[i] <= '0;
         vld_p1_q    <= 1'b0;
         last_p1_q   <= 1'b0;
         mode_p1_q   <= 1'b0;
         acc_q       <= '0;
         acc_sat_q   <= 1'b0;
         first_q     <= 1'b1;
         fire_p2_q   <= 1'b0;
         mode_p2_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         for (int i = 0; i < LANES; i++)
            prod_p1_q[i] <= prod_p1_d[i];
         vld_p1_q    <= vld_p1_d;
         last_p1_q   <= last_p1_d;
         mode_p1_q   <= mode_p1_d;
         acc_q       <= acc_d;
         acc_sat_q   <= acc_sat_d;
         first_q     <= first_d;
         fire_p2_q   <= fire_p2_d;
         mode_p2_q   <= mode_p2_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sat_q   <= out_sat_d;
      end
   end

   assign in_ready  = en;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;

endmodule
